tx_pi_pio: RTL and testbench
============================

// Module: tx_pi_pio
// PURPOSE
// - Downstream counterpart of the upstream nibble link: receives 4-bit nibble frames driven by the Raspberry Pi PIO.
// - Reassembles the nibbles into 24-bit words and presents them to gateware as a valid/ready stream.
// - Contains a small FIFO, because the Pi side has no backpressure.
// - Sits between the Pi GPIO pads (already synchronised to clk) and the TX sample path.
// PARAMETERS
// - FIFO_DEPTH  4   words buffered; power of 2, >= 2
// - DATA_W      24  assembled word width; fixed at 6 nibbles
// PORTS
// - clk              in   1             system clock; single clock domain
// - rst_n            in   1             asynchronous, active-low reset
// - ds_stream        in   4             nibble from Pi, sampled on every clk edge
// - ds_stream_valid  in   1             frame-start strobe, high for exactly 1 cycle per frame
// - ds_tdata         out  24            assembled word, MSB nibble first on the wire
// - ds_tvalid        out  1             ds_tdata valid
// - ds_tready        in   1             consumer accepts the word when ds_tvalid & ds_tready
// - ds_tfirst        out  1             word carried meta index 0 (first word of a packet)
// - fifo_level       out  $clog2(D)+1   current FIFO occupancy
// - seq_err          out  1             1-cycle pulse: meta index out of sequence
// - frame_err        out  1             1-cycle pulse: malformed or aborted frame
// - overflow         out  1             1-cycle pulse: word dropped because the FIFO was full
// BEHAVIOUR
// - Reset (async assert, sync release):
//   - state = IDLE, FIFO empty, expected index = 0.
//   - ds_tvalid = 0, ds_tdata = 0, ds_tfirst = 0, fifo_level = 0, all error pulses = 0.
// - Wire frame is 8 consecutive cycles:
//   - C0: ds_stream_valid = 1, nibble 4'h0 (sync).
//   - C1: meta nibble = frame index [3:0].
//   - C2..C7: data nibbles [23:20] down to [3:0].
//   - ds_stream_valid is low in C1..C7.
// - FSM states:
//   - IDLE: valid & nibble == 0 -> META.
//   - IDLE: valid & nibble != 0 -> frame_err pulse, stay in IDLE.
//   - META: capture the meta nibble -> D5.
//   - D5..D0: shift the nibble into the assembly register, one state per cycle; D0 -> IDLE.
//   - From D0, if ds_stream_valid & nibble == 0 arrives in that same cycle: the last nibble is taken as data, and the following cycle must be a fresh C0. Back-to-back frames need no idle gap, because C0 of the next frame is the cycle after D0.
// - Abort: ds_stream_valid high in META or D5..D0:
//   - Discard the partial word and pulse frame_err.
//   - If the nibble is 0, go to META (resync on the new frame); otherwise go to IDLE.
// - Sequence check, applied at META:
//   - meta == 0: ds_tfirst tagged for this word; expected = 1.
//   - meta == expected: expected = expected + 1, wrapping mod 16.
//   - Otherwise: seq_err pulse; word still delivered; expected = meta + 1.
// - Push into the FIFO happens on the clk edge that samples D0.
//   - FIFO entry holds {first, data}, 25 bits.
//   - If full at that edge and no pop occurs in the same cycle: drop the word, pulse overflow, FIFO unchanged.
//   - If full with a simultaneous pop: the push succeeds and there is no overflow.
// - FIFO behaviour:
//   - First-word-fall-through.
//   - ds_tvalid = !empty; it rises in the cycle after the push edge when the FIFO was empty.
//   - Latency: 7 clk from the edge sampling C0 to ds_tvalid.
//   - Pop = ds_tvalid & ds_tready.
//   - ds_tdata and ds_tfirst are held stable while ds_tvalid & !ds_tready.
//   - Push and pop in the same cycle leave fifo_level unchanged.
//   - Pointers wrap modulo FIFO_DEPTH.
// - Error pulses are registered, last exactly 1 cycle, and are mutually independent.
// - Reset mid-frame: any partial word is lost, the FIFO is cleared, and ds_tvalid drops immediately (asynchronously).
// STRUCTURE
// - Package pi_pio_pkg holds:
//   - state enum (IDLE, META, D5..D0);
//   - SYNC_NIBBLE = 4'h0, NIBBLES_PER_WORD = 6, FRAME_CYCLES = 8.
// - Sub-module tx_pi_pio_fifo: parameterised sync FWFT FIFO with level, full and empty outputs, async active-low reset.
// - Top level contains the FSM, the assembly shift register, the sequence checker and the error pulse registers.
// TESTING
// - Single frame, meta 0, data 0xABCDEF, ds_tready = 1:
//   - ds_tvalid high for 1 cycle with ds_tdata = 24'hABCDEF and ds_tfirst = 1.
//   - Latency 7 clk after C0; no error pulses.
// - Frames with meta 0,1,2,4, ds_tready = 1:
//   - 4 words delivered; seq_err pulses once (on meta 4).
//   - ds_tfirst = 1 only on the first word.
// - 6 back-to-back frames, ds_tready = 0, FIFO_DEPTH = 4:
//   - fifo_level reaches 4; overflow pulses twice.
//   - Releasing ds_tready outputs the first 4 words in order.
// - ds_stream_valid reasserted with nibble 0 at D3:
//   - frame_err pulses; the partial word is dropped.
//   - The new frame is received intact.
// - Stray valid with nibble 4'h5 in IDLE: frame_err pulses, no word is produced.
// - rst_n low mid-frame with the FIFO holding 2 words:
//   - ds_tvalid = 0 and fifo_level = 0 immediately.
//   - The next full frame is delivered correctly.

Source files
------------

// File: rtl/pi_pio_pkg.sv
// Shared types and constants for the Pi PIO nibble-frame receiver.
package pi_pio_pkg;

  // Order matters: D5..D0 advance by incrementing the encoding.
  typedef enum logic [2:0] {
    StIdle,
    StMeta,
    StD5,
    StD4,
    StD3,
    StD2,
    StD1,
    StD0
  } state_t;

  localparam logic [3:0]  SYNC_NIBBLE      = 4'h0;
  localparam int unsigned NIBBLES_PER_WORD = 6;
  localparam int unsigned FRAME_CYCLES     = 8;

endpackage

// File: rtl/tx_pi_pio_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy, full and empty flags.
module tx_pi_pio_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 25
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PtrOne  = AW'(1);
  localparam logic [AW:0]   CntOne  = (AW + 1)'(1);
  localparam logic [AW:0]   FullCnt = (AW + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign full    = (count_q == FullCnt);
  assign empty   = (count_q == '0);
  assign level   = count_q;
  // A full FIFO still accepts a write when the head is leaving in the same cycle.
  assign do_push = push & (~full | pop);
  assign do_pop  = pop & ~empty;
  assign rdata   = empty ? '0 : mem[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrOne;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrOne;
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CntOne;
        2'b01:   count_q <= count_q - CntOne;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/tx_pi_pio.sv
// Reassembles 8-cycle nibble frames from the Pi PIO into 24-bit words on a valid/ready stream.
module tx_pi_pio
  import pi_pio_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned DATA_W     = 24
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [3:0]                    ds_stream,
  input  logic                          ds_stream_valid,
  output logic [DATA_W-1:0]             ds_tdata,
  output logic                          ds_tvalid,
  input  logic                          ds_tready,
  output logic                          ds_tfirst,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          seq_err,
  output logic                          frame_err,
  output logic                          overflow
);

  localparam int unsigned AsmW = (NIBBLES_PER_WORD - 1) * 4;

  state_t          state_q;
  logic [AsmW-1:0] asm_q;
  logic            first_q;
  logic [3:0]      expected_q;
  logic            is_sync, push, pop, full, empty;

  assign is_sync   = (ds_stream == SYNC_NIBBLE);
  // The last nibble completes the word unless D0 is hit by a malformed start strobe.
  assign push      = (state_q == StD0) && !(ds_stream_valid && !is_sync);
  assign pop       = ds_tvalid & ds_tready;
  assign ds_tvalid = ~empty;

  tx_pi_pio_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W + 1)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .wdata ({first_q, asm_q, ds_stream}),
    .pop   (pop),
    .rdata ({ds_tfirst, ds_tdata}),
    .full  (full),
    .empty (empty),
    .level (fifo_level)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      asm_q      <= '0;
      first_q    <= 1'b0;
      expected_q <= 4'h0;
      seq_err    <= 1'b0;
      frame_err  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      seq_err   <= 1'b0;
      frame_err <= 1'b0;
      overflow  <= push & full & ~pop;
      unique case (state_q)
        StIdle: begin
          if (ds_stream_valid) begin
            if (is_sync) state_q <= StMeta;
            else         frame_err <= 1'b1;
          end
        end
        StMeta: begin
          if (ds_stream_valid) begin
            frame_err <= 1'b1;
            state_q   <= is_sync ? StMeta : StIdle;
          end else begin
            // Index 0 always restarts the sequence; any other index resyncs to itself.
            first_q    <= (ds_stream == 4'h0);
            seq_err    <= (ds_stream != 4'h0) && (ds_stream != expected_q);
            expected_q <= ds_stream + 4'd1;
            state_q    <= StD5;
          end
        end
        StD0: begin
          state_q <= StIdle;
          if (ds_stream_valid && !is_sync) frame_err <= 1'b1;
        end
        StD5, StD4, StD3, StD2, StD1: begin
          if (ds_stream_valid) begin
            frame_err <= 1'b1;
            state_q   <= is_sync ? StMeta : StIdle;
          end else begin
            asm_q   <= {asm_q[AsmW-5:0], ds_stream};
            state_q <= state_t'(state_q + 3'd1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_pi_pio.sv
// Scoreboard bench for tx_pi_pio: directed frames, monitor pops expected words on each handshake.
module tb_tx_pi_pio;
  import pi_pio_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  ds_stream = 4'h0;
  logic        ds_stream_valid = 1'b0;
  logic [23:0] ds_tdata;
  logic        ds_tvalid;
  logic        ds_tready = 1'b1;
  logic        ds_tfirst;
  logic [2:0]  fifo_level;
  logic        seq_err, frame_err, overflow;

  tx_pi_pio #(
    .FIFO_DEPTH (4),
    .DATA_W     (24)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .ds_stream       (ds_stream),
    .ds_stream_valid (ds_stream_valid),
    .ds_tdata        (ds_tdata),
    .ds_tvalid       (ds_tvalid),
    .ds_tready       (ds_tready),
    .ds_tfirst       (ds_tfirst),
    .fifo_level      (fifo_level),
    .seq_err         (seq_err),
    .frame_err       (frame_err),
    .overflow        (overflow)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          c0_cyc = 0;
  int          seq_cnt = 0, frm_cnt = 0, ovf_cnt = 0;
  int          b_seq, b_frm, b_ovf;
  logic        tv_pre;
  logic [24:0] sb [$];
  logic [24:0] exp_word;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: counts error pulses and checks every word the DUT presents.
  always @(negedge clk) begin
    if (rst_n) begin
      if (seq_err)   seq_cnt++;
      if (frame_err) frm_cnt++;
      if (overflow)  ovf_cnt++;
      if (ds_tvalid) begin
        if (sb.size() == 0) begin
          check("unexpected_word", 32'({ds_tfirst, ds_tdata}), 32'hFFFF_FFFF);
        end else if (ds_tready) begin
          exp_word = sb.pop_front();
          check("word", 32'({ds_tfirst, ds_tdata}), 32'(exp_word));
        end else begin
          check("hold", 32'({ds_tfirst, ds_tdata}), 32'(sb[0]));
        end
      end
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_tail(input logic [3:0] meta, input logic [23:0] d);
    ds_stream_valid = 1'b0;
    ds_stream = meta;
    tick();
    for (int i = 5; i >= 0; i--) begin
      ds_stream = d[i*4 +: 4];
      if (i == 0) tv_pre = ds_tvalid;
      tick();
    end
    ds_stream = 4'h0;
  endtask

  task automatic send_frame(input logic [3:0] meta, input logic [23:0] d, input logic keep,
                            input logic first);
    if (keep) sb.push_back({first, d});
    ds_stream_valid = 1'b1;
    ds_stream = SYNC_NIBBLE;
    tick();
    c0_cyc = cyc;
    send_tail(meta, d);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((sb.size() != 0 || ds_tvalid) && n < 40) begin
      tick();
      n++;
    end
    check(name, 32'(sb.size()), 32'd0);
  endtask

  task automatic snap();
    b_seq = seq_cnt;
    b_frm = frm_cnt;
    b_ovf = ovf_cnt;
  endtask

  task automatic check_pulses(input string name, input int s, input int f, input int o);
    check({name, "_seq_err"},   32'(seq_cnt - b_seq), 32'(s));
    check({name, "_frame_err"}, 32'(frm_cnt - b_frm), 32'(f));
    check({name, "_overflow"},  32'(ovf_cnt - b_ovf), 32'(o));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #12;
    check("rst_tvalid", 32'(ds_tvalid), 32'd0);
    check("rst_tdata", 32'(ds_tdata), 32'd0);
    check("rst_tfirst", 32'(ds_tfirst), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_pulses", 32'({seq_err, frame_err, overflow}), 32'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    tick();

    // Single frame, latency and one-cycle valid
    snap();
    send_frame(4'h0, 24'hABCDEF, 1'b1, 1'b1);
    check("latency_cycles", 32'(cyc - c0_cyc), 32'(FRAME_CYCLES - 1));
    check("tvalid_before", 32'(tv_pre), 32'd0);
    check("tvalid_rise", 32'(ds_tvalid), 32'd1);
    tick();
    check("tvalid_one_cycle", 32'(ds_tvalid), 32'd0);
    drain("t1_drain");
    check_pulses("t1", 0, 0, 0);

    // Sequence 0,1,2,4
    snap();
    send_frame(4'h0, 24'h111111, 1'b1, 1'b1);
    send_frame(4'h1, 24'h222222, 1'b1, 1'b0);
    send_frame(4'h2, 24'h333333, 1'b1, 1'b0);
    send_frame(4'h4, 24'h444444, 1'b1, 1'b0);
    drain("t2_drain");
    check_pulses("t2", 1, 0, 0);

    // Overflow: six frames with the consumer stalled
    snap();
    ds_tready = 1'b0;
    send_frame(4'h5, 24'hA00001, 1'b1, 1'b0);
    send_frame(4'h6, 24'hA00002, 1'b1, 1'b0);
    send_frame(4'h7, 24'hA00003, 1'b1, 1'b0);
    send_frame(4'h8, 24'hA00004, 1'b1, 1'b0);
    send_frame(4'h9, 24'hA00005, 1'b0, 1'b0);
    send_frame(4'hA, 24'hA00006, 1'b0, 1'b0);
    tick(2);
    check("t3_level_full", 32'(fifo_level), 32'd4);
    check_pulses("t3", 0, 0, 2);
    ds_tready = 1'b1;
    drain("t3_drain");
    check("t3_level_empty", 32'(fifo_level), 32'd0);

    // Abort at D3 with a new sync, then the new frame completes
    snap();
    ds_stream_valid = 1'b1;
    ds_stream = SYNC_NIBBLE;
    tick();
    ds_stream_valid = 1'b0;
    ds_stream = 4'hB;
    tick();
    ds_stream = 4'h9;
    tick();
    ds_stream = 4'h8;
    tick();
    ds_stream_valid = 1'b1;
    ds_stream = SYNC_NIBBLE;
    tick();
    sb.push_back({1'b0, 24'h123456});
    send_tail(4'hC, 24'h123456);
    drain("t4_drain");
    check_pulses("t4", 0, 1, 0);

    // Stray start strobe with a non-sync nibble
    snap();
    ds_stream_valid = 1'b1;
    ds_stream = 4'h5;
    tick();
    ds_stream_valid = 1'b0;
    ds_stream = 4'h0;
    tick(8);
    check("t5_no_word", 32'({ds_tvalid, fifo_level}), 32'd0);
    check_pulses("t5", 0, 1, 0);

    // Reset mid-frame with two words buffered
    ds_tready = 1'b0;
    send_frame(4'hD, 24'hC0FFEE, 1'b1, 1'b0);
    send_frame(4'hE, 24'hBEEF01, 1'b1, 1'b0);
    tick();
    check("t6_level_two", 32'(fifo_level), 32'd2);
    ds_stream_valid = 1'b1;
    ds_stream = SYNC_NIBBLE;
    tick();
    ds_stream_valid = 1'b0;
    ds_stream = 4'hF;
    tick();
    ds_stream = 4'h7;
    #2 rst_n = 1'b0;
    #1;
    check("t6_async_tvalid", 32'(ds_tvalid), 32'd0);
    check("t6_async_level", 32'(fifo_level), 32'd0);
    check("t6_async_tdata", 32'({ds_tfirst, ds_tdata}), 32'd0);
    sb.delete();
    ds_stream = 4'h0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    ds_tready = 1'b1;
    snap();
    send_frame(4'h0, 24'h5A5A5A, 1'b1, 1'b1);
    drain("t6_drain");
    check_pulses("t6", 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
